// File: rtl/stopwatch_pkg.sv
// ============================================================================
// stopwatch_pkg : shared types and constants for the tick_stopwatch slice
// Revision: 1.0
// ============================================================================
`default_nettype none

package stopwatch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2
  } sw_state_t;

  localparam int BCD_W    = 4;
  localparam int LIM_NINE = 9;
  localparam int LIM_FIVE = 5;

endpackage

`default_nettype wire

// File: rtl/bcd_digit.sv
// ============================================================================
// bcd_digit : one BCD counter digit wrapping at LIMIT, carry when stepping past it
// Revision: 1.0
// ============================================================================
`default_nettype none

module bcd_digit
  import stopwatch_pkg::*;
#(
  parameter int LIMIT = LIM_NINE
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             inc,
  output logic [BCD_W-1:0] q,
  output logic             carry
);

  localparam logic [BCD_W-1:0] LIM_Q = BCD_W'(LIMIT);

  logic at_limit;

  assign at_limit = (q == LIM_Q);
  assign carry    = inc && at_limit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (inc) begin
      q <= at_limit ? '0 : q + 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/tick_stopwatch.sv
// ============================================================================
// tick_stopwatch : mm:ss BCD stopwatch with run/pause/clear control and tick prescaler
// Optional lap freeze built when STOPWATCH_LAP_EN is defined.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tick_stopwatch
  import stopwatch_pkg::*;
#(
  parameter int TICKS_PER_SEC = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tick_in,
  input  logic             start_stop,
  input  logic             clr,
  input  logic             lap,
  output logic [BCD_W-1:0] sec_ones,
  output logic [BCD_W-1:0] sec_tens,
  output logic [BCD_W-1:0] min_ones,
  output logic [BCD_W-1:0] min_tens,
  output logic             running,
  output logic             wrap
);

  localparam logic [7:0] PRESC_LAST = 8'(TICKS_PER_SEC - 1);

  sw_state_t        state;
  sw_state_t        next_state;
  logic [7:0]       presc;
  logic             count_tick;
  logic             sec_inc;
  logic             c_so, c_st, c_mo, c_mt;
  logic [BCD_W-1:0] live_so, live_st, live_mo, live_mt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    if (clr) begin
      next_state = ST_IDLE;
    end else if (start_stop) begin
      case (state)
        ST_IDLE:  next_state = ST_RUN;
        ST_RUN:   next_state = ST_PAUSE;
        ST_PAUSE: next_state = ST_RUN;
        default:  next_state = ST_IDLE;
      endcase
    end
  end

  // Tick is judged against the pre-transition state, so RUN->PAUSE still counts it.
  assign count_tick = tick_in && !clr && (state == ST_RUN);
  assign sec_inc    = count_tick && (presc == PRESC_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc <= '0;
    end else if (clr) begin
      presc <= '0;
    end else if (count_tick) begin
      presc <= sec_inc ? 8'd0 : presc + 8'd1;
    end
  end

  bcd_digit #(.LIMIT(LIM_NINE)) u_sec_ones (
    .clk(clk), .rst_n(rst_n), .clr(clr), .inc(sec_inc), .q(live_so), .carry(c_so)
  );
  bcd_digit #(.LIMIT(LIM_FIVE)) u_sec_tens (
    .clk(clk), .rst_n(rst_n), .clr(clr), .inc(c_so), .q(live_st), .carry(c_st)
  );
  bcd_digit #(.LIMIT(LIM_NINE)) u_min_ones (
    .clk(clk), .rst_n(rst_n), .clr(clr), .inc(c_st), .q(live_mo), .carry(c_mo)
  );
  bcd_digit #(.LIMIT(LIM_FIVE)) u_min_tens (
    .clk(clk), .rst_n(rst_n), .clr(clr), .inc(c_mo), .q(live_mt), .carry(c_mt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      running <= 1'b0;
      wrap    <= 1'b0;
    end else begin
      running <= (next_state == ST_RUN);
      wrap    <= c_mt;
    end
  end

`ifdef STOPWATCH_LAP_EN
  logic                   lap_flag;
  logic [4*BCD_W-1:0]     lap_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lap_flag <= 1'b0;
      lap_reg  <= '0;
    end else if (clr || start_stop) begin
      lap_flag <= 1'b0;
    end else if (lap) begin
      if (lap_flag) begin
        lap_flag <= 1'b0;
      end else if (state == ST_RUN) begin
        lap_flag <= 1'b1;
        lap_reg  <= {live_mt, live_mo, live_st, live_so};
      end
    end
  end

  assign sec_ones = lap_flag ? lap_reg[BCD_W-1:0]         : live_so;
  assign sec_tens = lap_flag ? lap_reg[2*BCD_W-1:BCD_W]   : live_st;
  assign min_ones = lap_flag ? lap_reg[3*BCD_W-1:2*BCD_W] : live_mo;
  assign min_tens = lap_flag ? lap_reg[4*BCD_W-1:3*BCD_W] : live_mt;
`else
  logic unused_lap;

  assign unused_lap = lap;
  assign sec_ones   = live_so;
  assign sec_tens   = live_st;
  assign min_ones   = live_mo;
  assign min_tens   = live_mt;
`endif

endmodule

`default_nettype wire

// File: tb/tb_tick_stopwatch.sv
// ============================================================================
// tb_tick_stopwatch : directed + random stimulus against a seconds-count model
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_tick_stopwatch;

  localparam int M_IDLE  = 0;
  localparam int M_RUN   = 1;
  localparam int M_PAUSE = 2;
`ifdef STOPWATCH_LAP_EN
  localparam bit LAP_EN = 1'b1;
`else
  localparam bit LAP_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic tick_in = 1'b0, start_stop = 1'b0, clr = 1'b0, lap = 1'b0;
  logic [3:0] so0, st0, mo0, mt0, so1, st1, mo1, mt1;
  logic run0, wrap0, run1, wrap1;

  tick_stopwatch #(.TICKS_PER_SEC(1)) dut0 (
    .clk(clk), .rst_n(rst_n), .tick_in(tick_in), .start_stop(start_stop), .clr(clr), .lap(lap),
    .sec_ones(so0), .sec_tens(st0), .min_ones(mo0), .min_tens(mt0), .running(run0), .wrap(wrap0)
  );
  tick_stopwatch #(.TICKS_PER_SEC(3)) dut1 (
    .clk(clk), .rst_n(rst_n), .tick_in(tick_in), .start_stop(start_stop), .clr(clr), .lap(lap),
    .sec_ones(so1), .sec_tens(st1), .min_ones(mo1), .min_tens(mt1), .running(run1), .wrap(wrap1)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: elapsed seconds as a plain integer, converted to mm:ss on demand.
  int tps[2] = '{1, 3};
  int m_state[2], m_pre[2], m_secs[2], m_lapsecs[2];
  bit m_wrap[2], m_flag[2];

  task automatic model_step(input int i);
    int old;
    m_wrap[i] = 1'b0;
    if (clr) begin
      m_state[i] = M_IDLE; m_pre[i] = 0; m_secs[i] = 0; m_flag[i] = 1'b0;
    end else begin
      old = m_secs[i];
      if (start_stop) m_flag[i] = 1'b0;
      else if (LAP_EN && lap) begin
        if (m_flag[i]) m_flag[i] = 1'b0;
        else if (m_state[i] == M_RUN) begin
          m_flag[i] = 1'b1; m_lapsecs[i] = old;
        end
      end
      if (tick_in && m_state[i] == M_RUN) begin
        m_pre[i]++;
        if (m_pre[i] == tps[i]) begin
          m_pre[i] = 0;
          m_secs[i]++;
          if (m_secs[i] == 3600) begin
            m_secs[i] = 0; m_wrap[i] = 1'b1;
          end
        end
      end
      if (start_stop) m_state[i] = (m_state[i] == M_RUN) ? M_PAUSE : M_RUN;
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        m_state[i] = M_IDLE; m_pre[i] = 0; m_secs[i] = 0; m_lapsecs[i] = 0;
        m_wrap[i] = 1'b0; m_flag[i] = 1'b0;
      end
    end else begin
      for (int i = 0; i < 2; i++) model_step(i);
    end
  end

  function automatic logic [15:0] bcd(input int s);
    int m, x;
    m = s / 60; x = s % 60;
    return {4'(m / 10), 4'(m % 10), 4'(x / 10), 4'(x % 10)};
  endfunction

  function automatic logic [17:0] exp_out(input int i);
    int shown;
    shown = m_flag[i] ? m_lapsecs[i] : m_secs[i];
    return {bcd(shown), (m_state[i] == M_RUN), m_wrap[i]};
  endfunction

  always @(negedge clk) begin
    check("cycle_dut0", {14'd0, mt0, mo0, st0, so0, run0, wrap0}, {14'd0, exp_out(0)});
    check("cycle_dut1", {14'd0, mt1, mo1, st1, so1, run1, wrap1}, {14'd0, exp_out(1)});
  end

  task automatic step(input bit t, input bit ss, input bit c, input bit lp);
    tick_in = t; start_stop = ss; clr = c; lap = lp;
    @(negedge clk);
  endtask

  task automatic ticks(input int n);
    repeat (n) step(1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic chk0(input string name, input logic [15:0] digits, input logic run);
    check({name, "_digits"}, {16'd0, mt0, mo0, st0, so0}, {16'd0, digits});
    check({name, "_running"}, {31'd0, run0}, {31'd0, run});
  endtask

  initial begin
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk0("reset", 16'h0000, 1'b0);
    check("reset_wrap", {31'd0, wrap0}, 32'd0);
    rst_n = 1'b1;

    ticks(3);
    chk0("idle_ticks", 16'h0000, 1'b0);

    step(1'b0, 1'b1, 1'b0, 1'b0);
    ticks(5);
    chk0("five_ticks", 16'h0005, 1'b1);

    step(1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    ticks(59);
    chk0("t0059", 16'h0059, 1'b1);
    ticks(1);
    chk0("t0100", 16'h0100, 1'b1);
    ticks(3539);
    chk0("t5959", 16'h5959, 1'b1);
    check("pre_wrap", {31'd0, wrap0}, 32'd0);
    ticks(1);
    chk0("t0000", 16'h0000, 1'b1);
    check("wrap_pulse", {31'd0, wrap0}, 32'd1);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    check("wrap_one_cycle", {31'd0, wrap0}, 32'd0);

    // Prescaler held through PAUSE on the TICKS_PER_SEC=3 instance.
    step(1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    ticks(2);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    ticks(4);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    ticks(1);
    check("presc_hold_dut1", {16'd0, mt1, mo1, st1, so1}, 32'h0001);
    check("presc_hold_run1", {31'd0, run1}, 32'd1);

    step(1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    ticks(7);
    chk0("t0007", 16'h0007, 1'b1);
    step(1'b1, 1'b0, 1'b1, 1'b0);
    chk0("clr_with_tick", 16'h0000, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    ticks(3);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    chk0("ss_with_tick", 16'h0004, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    chk0("pause_ignores", 16'h0004, 1'b0);

    step(1'b0, 1'b1, 1'b0, 1'b0);
    ticks(2);
    chk0("pre_async", 16'h0006, 1'b1);
    tick_in = 1'b1;
    #3 rst_n = 1'b0;
    #1;
    chk0("async_reset", 16'h0000, 1'b0);
    check("async_reset_dut1", {16'd0, mt1, mo1, st1, so1}, 32'h0000);
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b1, 1'b0, 1'b0, 1'b0);
    chk0("after_release", 16'h0000, 1'b0);

`ifdef STOPWATCH_LAP_EN
    step(1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    ticks(3);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    ticks(4);
    chk0("lap_frozen", 16'h0003, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    chk0("lap_release", 16'h0007, 1'b1);
`endif

    repeat (4000) begin
      step(1'($urandom_range(0, 1)), 1'($urandom % 16 == 0),
           1'($urandom % 256 == 0), 1'($urandom % 16 == 0));
    end
    step(1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
